reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter ENTRIES, default 4, number of buffered instructions (power of two, 2..16).
REQ-002 Parameter OP_W, default 8, opcode width carried through unmodified.
REQ-003 Parameter TAG_W, default 6, ROB tag width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 dispatch_valid  in  1  dispatch request this cycle.
REQ-007 dispatch_ready  out  1  at least one free entry.
REQ-008 dispatch_op  in  OP_W  opcode.
REQ-009 dispatch_dest_tag  in  TAG_W  ROB tag of the result.
REQ-010 dispatch_src1, dispatch_src2  in  33 each  operand: bit32=1 -> bits[31:0] value; bit32=0 -> bits[TAG_W-1:0] pending tag, other bits zero.
REQ-011 cdb_valid  in  1  result broadcast valid.
REQ-012 cdb_tag  in  TAG_W  broadcast producer tag.
REQ-013 cdb_data  in  32  broadcast value.
REQ-014 flush  in  1  synchronous discard of all entries.
REQ-015 issue_valid  out  1  a ready entry is presented.
REQ-016 issue_ready  in  1  execution unit accepts.
REQ-017 issue_op, issue_dest_tag, issue_data1, issue_data2  out  OP_W/TAG_W/32/32  selected entry contents.

Function
REQ-018 Entry state: valid, op, dest_tag, and per operand a ready flag plus 32-bit value-or-tag field.
REQ-019 dispatch_ready SHALL be 1 when any entry is invalid; derived from registered state only, independent of same-cycle issue.
REQ-020 Dispatch fires on dispatch_valid && dispatch_ready; writes lowest-index invalid entry at the next edge.
REQ-021 dispatch_valid while dispatch_ready=0 SHALL be ignored without state change.
REQ-022 Dispatched operand with bit32=0 whose tag equals cdb_tag while cdb_valid=1 in the same cycle SHALL be stored ready with cdb_data (dispatch bypass).
REQ-023 Every valid entry's non-ready operand whose tag equals cdb_tag while cdb_valid=1 SHALL become ready with cdb_data at the next edge; both operands may wake simultaneously.
REQ-024 An entry is eligible when valid and both operands ready, evaluated from registered state; CDB wake-up makes an entry eligible one cycle later, never combinationally.
REQ-025 issue_valid SHALL be 1 when any entry is eligible; issue outputs show the lowest-index eligible entry combinationally.
REQ-026 issue_valid && issue_ready SHALL invalidate the selected entry at the next edge.
REQ-027 Issue and dispatch in the same cycle are both permitted; if full, the freed entry is not available to that cycle's dispatch.
REQ-028 Issue outputs with issue_valid=0 are don't-care but SHALL be driven to zero.
REQ-029 flush=1 SHALL invalidate every entry at the next edge, overriding dispatch, wake-up and issue in that cycle.
REQ-030 Selection and allocation are purely index-priority; no age ordering is guaranteed.

Reset
REQ-031 rst=1 SHALL asynchronously clear every entry valid bit; payload registers need no reset.
REQ-032 During and after reset, dispatch_ready=1, issue_valid=0, and issue data outputs are 0.
REQ-033 Reset asserted mid-operation SHALL drop all buffered entries with no issue occurring.

Structure
REQ-034 Shared package SHALL hold TAG_W, DATA_W=32, the 33-bit operand typedef and operand field constants, also used by the operand-source mux.
REQ-035 One sub-module, rs_select, SHALL implement the lowest-index one-hot priority encoder used for both allocation and issue selection.

Verification
REQ-036 Dispatch op=0x11, dest=5, src1={1,0x0A}, src2={1,0x14}, issue_ready=1 -> issue_valid next cycle, data1=0x0A, data2=0x14, dest_tag=5; entry freed.
REQ-037 Dispatch src1 tag 3 pending; two cycles later cdb_valid tag=3 data=0xDEAD -> issue_valid rises exactly one cycle after broadcast with data1=0xDEAD.
REQ-038 Dispatch src1 tag 7 with cdb_valid tag=7 data=0x55 same cycle -> entry ready immediately, issue_valid next cycle with data1=0x55.
REQ-039 Fill 4 entries with pending tags -> dispatch_ready=0; 5th dispatch ignored; wake entry 2 then issue -> dispatch_ready returns 1 the following cycle.
REQ-040 Two eligible entries (0 and 2), issue_ready=1 -> entry 0 issues first, entry 2 next cycle; flush with 3 valid entries -> issue_valid=0, dispatch_ready=1 next cycle; async rst mid-stream clears immediately.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared operand encoding for the reservation station: widths, the 33-bit operand
// type, and the operand-source mux used when an instruction is dispatched.
package reservation_station_pkg;

    localparam int TAG_W          = 6;
    localparam int DATA_W         = 32;
    localparam int OPND_W         = DATA_W + 1;
    localparam int OPND_READY_BIT = DATA_W;

    typedef logic [OPND_W-1:0] operand_t;

    typedef struct packed {
        logic              ready;
        logic [DATA_W-1:0] field;
    } opnd_state_t;

    // A pending operand whose producer is on the CDB this cycle is captured ready.
    function automatic opnd_state_t capture_operand(input operand_t          src,
                                                    input logic              cdb_hit,
                                                    input logic [DATA_W-1:0] cdb_data);
        opnd_state_t res;
        if (src[OPND_READY_BIT]) begin
            res = '{ready: 1'b1, field: src[DATA_W-1:0]};
        end else if (cdb_hit) begin
            res = '{ready: 1'b1, field: cdb_data};
        end else begin
            res = '{ready: 1'b0, field: src[DATA_W-1:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Lowest-index priority encoder producing a one-hot grant; shared by entry
// allocation and issue selection.
module rs_select #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    // Two's-complement trick isolates the lowest set bit.
    assign grant = req & (~req + N'(1));

endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched instructions, wakes pending operands from
// the CDB, and issues the lowest-index entry whose operands are both ready.
module reservation_station #(
    parameter int ENTRIES = 4,
    parameter int OP_W    = 8,
    parameter int TAG_W   = reservation_station_pkg::TAG_W
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      dispatch_valid,
    output logic                                      dispatch_ready,
    input  logic [OP_W-1:0]                           dispatch_op,
    input  logic [TAG_W-1:0]                          dispatch_dest_tag,
    input  reservation_station_pkg::operand_t         dispatch_src1,
    input  reservation_station_pkg::operand_t         dispatch_src2,
    input  logic                                      cdb_valid,
    input  logic [TAG_W-1:0]                          cdb_tag,
    input  logic [reservation_station_pkg::DATA_W-1:0] cdb_data,
    input  logic                                      flush,
    output logic                                      issue_valid,
    input  logic                                      issue_ready,
    output logic [OP_W-1:0]                           issue_op,
    output logic [TAG_W-1:0]                          issue_dest_tag,
    output logic [reservation_station_pkg::DATA_W-1:0] issue_data1,
    output logic [reservation_station_pkg::DATA_W-1:0] issue_data2
);

    import reservation_station_pkg::*;

    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] rdy1;
    logic [ENTRIES-1:0] rdy2;
    logic [OP_W-1:0]    op_q   [ENTRIES];
    logic [TAG_W-1:0]   dest_q [ENTRIES];
    logic [DATA_W-1:0]  fld1   [ENTRIES];
    logic [DATA_W-1:0]  fld2   [ENTRIES];

    logic [ENTRIES-1:0] eligible;
    logic [ENTRIES-1:0] alloc_grant;
    logic [ENTRIES-1:0] issue_grant;
    logic               dispatch_fire;
    logic               issue_fire;
    logic               hit1;
    logic               hit2;
    opnd_state_t        new1;
    opnd_state_t        new2;

    assign eligible = valid & rdy1 & rdy2;

    rs_select #(.N(ENTRIES)) u_alloc_sel (.req(~valid),   .grant(alloc_grant));
    rs_select #(.N(ENTRIES)) u_issue_sel (.req(eligible), .grant(issue_grant));

    assign dispatch_ready = ~&valid;
    assign issue_valid    = |eligible;
    assign dispatch_fire  = dispatch_valid && dispatch_ready;
    assign issue_fire     = issue_valid && issue_ready;

    assign hit1 = cdb_valid && !dispatch_src1[OPND_READY_BIT] && (dispatch_src1[TAG_W-1:0] == cdb_tag);
    assign hit2 = cdb_valid && !dispatch_src2[OPND_READY_BIT] && (dispatch_src2[TAG_W-1:0] == cdb_tag);
    assign new1 = capture_operand(dispatch_src1, hit1, cdb_data);
    assign new2 = capture_operand(dispatch_src2, hit2, cdb_data);

    // The slot freed by issue is not in alloc_grant this cycle, so the two never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            valid <= (valid & ~(issue_fire ? issue_grant : '0))
                   | (dispatch_fire ? alloc_grant : '0);
        end
    end

    // NOTE: payload and ready flags are never read unless valid is set, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (dispatch_fire && alloc_grant[i]) begin
                op_q[i]   <= dispatch_op;
                dest_q[i] <= dispatch_dest_tag;
                rdy1[i]   <= new1.ready;
                fld1[i]   <= new1.field;
                rdy2[i]   <= new2.ready;
                fld2[i]   <= new2.field;
            end else if (valid[i] && cdb_valid) begin
                if (!rdy1[i] && fld1[i][TAG_W-1:0] == cdb_tag) begin
                    rdy1[i] <= 1'b1;
                    fld1[i] <= cdb_data;
                end
                if (!rdy2[i] && fld2[i][TAG_W-1:0] == cdb_tag) begin
                    rdy2[i] <= 1'b1;
                    fld2[i] <= cdb_data;
                end
            end
        end
    end

    // NOTE: every output gets a zero default first, so no latch and zero when nothing is eligible.
    always_comb begin
        issue_op       = '0;
        issue_dest_tag = '0;
        issue_data1    = '0;
        issue_data2    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (issue_grant[i]) begin
                issue_op       = issue_op | op_q[i];
                issue_dest_tag = issue_dest_tag | dest_q[i];
                issue_data1    = issue_data1 | fld1[i];
                issue_data2    = issue_data2 | fld2[i];
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: stimulus pushes expected issues into a
// queue, a negedge monitor pops and compares every accepted issue.
module tb_reservation_station;

    typedef struct packed {
        logic [7:0]  op;
        logic [5:0]  dest;
        logic [31:0] d1;
        logic [31:0] d2;
    } issue_t;

    logic        clk;
    logic        rst;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [7:0]  dispatch_op;
    logic [5:0]  dispatch_dest_tag;
    logic [32:0] dispatch_src1;
    logic [32:0] dispatch_src2;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic [7:0]  issue_op;
    logic [5:0]  issue_dest_tag;
    logic [31:0] issue_data1;
    logic [31:0] issue_data2;

    issue_t exp_q[$];
    int     n_vec = 0;
    int     n_bad = 0;

    reservation_station dut (
        .clk               (clk),
        .rst               (rst),
        .dispatch_valid    (dispatch_valid),
        .dispatch_ready    (dispatch_ready),
        .dispatch_op       (dispatch_op),
        .dispatch_dest_tag (dispatch_dest_tag),
        .dispatch_src1     (dispatch_src1),
        .dispatch_src2     (dispatch_src2),
        .cdb_valid         (cdb_valid),
        .cdb_tag           (cdb_tag),
        .cdb_data          (cdb_data),
        .flush             (flush),
        .issue_valid       (issue_valid),
        .issue_ready       (issue_ready),
        .issue_op          (issue_op),
        .issue_dest_tag    (issue_dest_tag),
        .issue_data1       (issue_data1),
        .issue_data2       (issue_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [77:0] got, input logic [77:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Handshake completes at the next rising edge; inputs only change just after an edge.
    always @(negedge clk) begin
        if (!rst && issue_valid && issue_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_issue: got %h expected none",
                         {issue_op, issue_dest_tag, issue_data1, issue_data2});
            end else begin
                check("issue", {issue_op, issue_dest_tag, issue_data1, issue_data2}, exp_q.pop_front());
            end
        end
    end

    function automatic logic [32:0] rv(input logic [31:0] v);
        return {1'b1, v};
    endfunction

    function automatic logic [32:0] pt(input logic [5:0] t);
        return {27'd0, t};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [7:0] op, input logic [5:0] dest,
                        input logic [32:0] s1, input logic [32:0] s2);
        dispatch_valid    = 1'b1;
        dispatch_op       = op;
        dispatch_dest_tag = dest;
        dispatch_src1     = s1;
        dispatch_src2     = s2;
    endtask

    task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
    endtask

    task automatic idle();
        dispatch_valid = 1'b0;
        cdb_valid      = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        dispatch_valid = 1'b0; dispatch_op = '0; dispatch_dest_tag = '0;
        dispatch_src1 = '0; dispatch_src2 = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        flush = 1'b0; issue_ready = 1'b1;

        // Reset state
        #12;
        check("rst_dispatch_ready", dispatch_ready, 1);
        check("rst_issue_valid", issue_valid, 0);
        check("rst_issue_data", {issue_op, issue_dest_tag, issue_data1, issue_data2}, 0);
        step();
        rst = 1'b0;
        check("post_rst_issue_valid", issue_valid, 0);

        // Both operands ready at dispatch
        disp(8'h11, 6'd5, rv(32'h0A), rv(32'h14));
        exp_q.push_back('{8'h11, 6'd5, 32'h0A, 32'h14});
        step(); idle();
        check("ready_dispatch_issue_valid", issue_valid, 1);
        step();
        check("ready_dispatch_freed", issue_valid, 0);
        check("ready_dispatch_dready", dispatch_ready, 1);

        // Pending src1 woken two cycles after dispatch
        disp(8'h22, 6'd1, pt(6'd3), rv(32'h7));
        step(); idle();
        check("pending_no_issue_0", issue_valid, 0);
        step();
        check("pending_no_issue_1", issue_valid, 0);
        cdb(6'd3, 32'hDEAD);
        exp_q.push_back('{8'h22, 6'd1, 32'hDEAD, 32'h7});
        #1 check("wake_not_combinational", issue_valid, 0);
        step(); idle();
        check("wake_issue_valid", issue_valid, 1);
        step();
        check("wake_freed", issue_valid, 0);

        // Dispatch bypass from same-cycle CDB
        disp(8'h33, 6'd2, pt(6'd7), rv(32'h9));
        cdb(6'd7, 32'h55);
        exp_q.push_back('{8'h33, 6'd2, 32'h55, 32'h9});
        step(); idle();
        check("bypass_issue_valid", issue_valid, 1);
        step();
        check("bypass_freed", issue_valid, 0);

        // Both operands on one tag; a non-matching broadcast must not wake
        disp(8'h66, 6'd6, pt(6'd9), pt(6'd9));
        step(); idle();
        cdb(6'd8, 32'h1234);
        step(); idle();
        check("wrong_tag_no_wake", issue_valid, 0);
        cdb(6'd9, 32'h77);
        exp_q.push_back('{8'h66, 6'd6, 32'h77, 32'h77});
        step(); idle();
        check("dual_wake_issue_valid", issue_valid, 1);
        step();
        check("dual_wake_freed", issue_valid, 0);

        // Full station: issue frees a slot but same-cycle dispatch is still refused
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(8'h50 + 8'(i), 6'(i), rv(32'h100 + 32'(i)), rv(32'h200 + 32'(i)));
            exp_q.push_back('{8'h50 + 8'(i), 6'(i), 32'h100 + 32'(i), 32'h200 + 32'(i)});
            step();
        end
        idle();
        check("full_dready", dispatch_ready, 0);
        check("full_issue_valid", issue_valid, 1);
        disp(8'h5F, 6'd9, rv(32'h1), rv(32'h2));
        issue_ready = 1'b1;
        step(); idle();
        check("full_issue_no_refill", dispatch_ready, 1);
        repeat (3) step();
        check("full_drained", issue_valid, 0);

        // Fill with pending entries, fifth dispatch ignored, wake entry 2
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(8'h40 + 8'(i), 6'd20 + 6'(i), pt(6'd10 + 6'(i)), rv(32'(i)));
            step();
        end
        idle();
        check("pending_full_dready", dispatch_ready, 0);
        disp(8'h44, 6'd24, rv(32'h1), rv(32'h2));
        step(); idle();
        check("fifth_ignored_issue", issue_valid, 0);
        check("fifth_ignored_dready", dispatch_ready, 0);
        cdb(6'd12, 32'hC2);
        exp_q.push_back('{8'h42, 6'd22, 32'hC2, 32'h2});
        step(); idle();
        check("entry2_eligible", issue_valid, 1);
        check("entry2_still_full", dispatch_ready, 0);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        check("entry2_freed_dready", dispatch_ready, 1);
        check("entry2_freed_issue", issue_valid, 0);

        // Flush with three valid entries overrides dispatch and wake-up
        flush = 1'b1;
        disp(8'h77, 6'd7, rv(32'h1), rv(32'h2));
        cdb(6'd10, 32'h5);
        step();
        flush = 1'b0;
        idle();
        check("flush_issue_valid", issue_valid, 0);
        check("flush_dready", dispatch_ready, 1);
        step();
        check("flush_dispatch_dropped", issue_valid, 0);

        // Entries 0 and 2 eligible: index priority
        disp(8'h80, 6'd0, rv(32'h80), rv(32'h1));
        exp_q.push_back('{8'h80, 6'd0, 32'h80, 32'h1});
        step();
        disp(8'h81, 6'd1, pt(6'd31), rv(32'h2));
        step();
        disp(8'h82, 6'd2, rv(32'h82), rv(32'h3));
        exp_q.push_back('{8'h82, 6'd2, 32'h82, 32'h3});
        step(); idle();
        check("prio_issue_valid", issue_valid, 1);
        issue_ready = 1'b1;
        step();
        check("prio_second_pending", issue_valid, 1);
        step();
        issue_ready = 1'b0;
        check("prio_done", issue_valid, 0);

        // Asynchronous reset mid-stream drops an eligible entry at once
        cdb(6'd31, 32'h31);
        step(); idle();
        check("pre_rst_eligible", issue_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_issue_valid", issue_valid, 0);
        check("async_rst_issue_data", {issue_op, issue_dest_tag, issue_data1, issue_data2}, 0);
        check("async_rst_dready", dispatch_ready, 1);
        step();
        rst = 1'b0;
        step();
        check("after_rst_issue_valid", issue_valid, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
